panel_led_shift: RTL and testbench
==================================

# panel_led_shift

Serial LED driver stage downstream of the `D_mux` display multiplexer. Snapshots the 12-bit display word, the five display-select indicators and the run indicator. Shifts them into a chain of three 74HC595 shift registers on the front-panel board, then strobes the storage latch. Frames run periodically, and optionally immediately on any change of the displayed data.

## Interface

Parameters:
- `CLK_DIV`, default 4: half-period of `sr_clk` in `clk` cycles; legal range ≥1.
- `REFRESH`, default 50000: `clk` cycles spent in IDLE between frames; legal range ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `dout`  in  [0:11]  display word from `D_mux`.
- `dsel_led`  in  [0:4]  display-select indicators from `D_mux`.
- `run_led`  in  1  run indicator from `D_mux`.
- `sr_data`  out  1  serial data to the first 74HC595 SER pin.
- `sr_clk`  out  1  shift clock to SRCLK; data is sampled on the rising edge.
- `sr_latch`  out  1  storage strobe to RCLK; active high.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation

Frame word is 24 bits: `{6'b000000, run_led, dsel_led[0:4], dout[0:11]}`.
- Bit 23 is shifted first and bit 0 last.
- `dout[11]` is bit 0; `run_led` is bit 17.

FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- **IDLE:** refresh counter decrements. When it reaches 0, go to LOAD.
- **LOAD (1 clk):**
  - Capture the frame word into the shift register and the `last` snapshot register.
  - Bit counter := 23.
  - `sr_data` := word[23].
  - `busy` := 1.
- **SHIFT_LO (`CLK_DIV` clks):** `sr_clk`=0, `sr_data` stable. Then go to SHIFT_HI.
- **SHIFT_HI (`CLK_DIV` clks):** `sr_clk`=1, `sr_data` stable. On exit:
  - If the bit counter is 0, go to LATCH.
  - Otherwise decrement the counter, shift left, present the next bit on `sr_data`, and go to SHIFT_LO.
- **LATCH (`CLK_DIV` clks):** `sr_clk`=0, `sr_latch`=1. On exit:
  - `sr_latch`=0, `busy`=0.
  - Pulse `frame_done` for 1 clk.
  - Reload the refresh counter with `REFRESH-1`.
  - Go to IDLE.

Boundary rules:
- Inputs are ignored from LOAD until the end of LATCH; the frame always ships the LOAD-time snapshot.
- Reset clears the refresh counter to 0, so the first frame starts right after reset deasserts and initialises the LEDs.
- Reset mid-frame aborts the frame. `sr_latch` never asserts for a partial frame, so the 595 outputs keep the last complete frame.
- `sr_data` holds word[0] through LATCH. In IDLE, `sr_data`=0.
- The bit counter is 5 bits wide. The refresh counter is `$clog2(REFRESH+1)` bits wide and never wraps below 0.

## Timing

- Reset values: `sr_data`=0, `sr_clk`=0, `sr_latch`=0, `busy`=0, `frame_done`=0, FSM=IDLE, refresh counter=0.
- First LOAD occurs on the first `clk` edge after reset deasserts, plus 1 edge for the IDLE count check.
- Frame length is `1 + 24·2·CLK_DIV + CLK_DIV` clks. With `CLK_DIV`=4 this is 197 clks.
- `busy` is high for exactly the frame length.
- Spacing between frames is `REFRESH` clks of IDLE, measured from the `frame_done` pulse to the next LOAD.
- Setup at the 595: `sr_data` changes only on the `sr_clk` falling transition (SHIFT_HI→SHIFT_LO). This gives `CLK_DIV` clks of setup and `CLK_DIV` clks of hold.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration

`LED_CHANGE_EN`:
- **Defined:**
  - A comparator compares the current frame word with `last`.
  - In IDLE, any mismatch goes to LOAD on the next clk, regardless of the refresh counter.
  - A mismatch arising during a frame is evaluated in the first IDLE cycle after `frame_done`, so the new frame starts 1 clk later.
  - The periodic refresh still runs.
- **Undefined:**
  - The comparator and `last` register are not built.
  - Frames start only on refresh expiry, so display latency is up to `REFRESH` + frame length.

## Test plan

- **Reset values:** Hold `reset`=0 for 5 clks → all outputs 0. Release → `busy` rises within 2 clks.
- **Frame content:** `CLK_DIV`=4, `dout`=12'o1111, `dsel_led`=5'b00001, `run_led`=1 → 24 bits sampled on `sr_clk` rising edges equal 24'h021249, MSB first. Exactly one `sr_latch` pulse, 4 clks wide, after the 24th rising edge.
- **Frame timing:** `busy` high for 197 clks. `frame_done` is a single pulse. Next LOAD follows exactly `REFRESH` clks after `frame_done` (use `REFRESH`=10 in the bench).
- **Mid-frame input change:** Change `dout` to 12'o7777 mid-shift → current frame still ships 24'h021249.
  - With `LED_CHANGE_EN`: the next frame starts 1 clk after `frame_done` and ships 24'h021FFF.
  - Without `LED_CHANGE_EN`: the next frame starts after `REFRESH` clks.
- **Reset mid-frame:** Assert `reset` after 10 shift bits → `sr_latch` never pulses for that frame. Outputs go to 0 immediately, and a full frame restarts after release.
- **Minimum `CLK_DIV`:** `CLK_DIV`=1 → frame length 50 clks, data is correct, and `sr_clk` toggles every clk during shifting.

Source files
------------

// File: rtl/panel_led_shift.sv
// Front-panel LED driver: serialises the 24-bit display frame into three chained 74HC595s.
// Optional LED_CHANGE_EN also starts a frame as soon as the displayed data changes.
module panel_led_shift #(
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] dout,
    input  logic [0:4]  dsel_led,
    input  logic        run_led,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam int RW = $clog2(REFRESH + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [RW-1:0] REF_LOAD = RW'(REFRESH - 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t          state;
    logic [RW-1:0]   refresh_cnt;
    logic [DW-1:0]   div_cnt;
    logic [4:0]      bit_cnt;
    logic [22:0]     shift_reg;
    logic [23:0]     cur_word;
    logic            change_req;
    logic            start_frame;
    logic            shift_step;

    // Index 0 of each ascending input vector is its most significant bit in the frame.
    function automatic logic [23:0] pack_frame(input logic [0:11] d,
                                               input logic [0:4]  s,
                                               input logic        r);
        return {6'b000000, r, s, d};
    endfunction

    assign cur_word    = pack_frame(dout, dsel_led, run_led);
    assign start_frame = (state == IDLE) && ((refresh_cnt == '0) || change_req);
    assign shift_step  = (state == SHIFT_HI) && (div_cnt == '0) && (bit_cnt != '0);

`ifdef LED_CHANGE_EN
    logic [23:0] last_word;

    always_ff @(posedge clk) begin
        if (start_frame)
            last_word <= cur_word;
    end

    assign change_req = (cur_word != last_word);
`else
    assign change_req = 1'b0;
`endif

    // Frame snapshot: bit 23 goes straight to sr_data, the rest waits here.
    always_ff @(posedge clk) begin
        if (start_frame)
            shift_reg <= cur_word[22:0];
        else if (shift_step)
            shift_reg <= {shift_reg[21:0], 1'b0};
    end

    // Sequencer: every output is registered and changes only on state exits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            refresh_cnt <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sr_data     <= 1'b0;
            sr_clk      <= 1'b0;
            sr_latch    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        sr_data <= cur_word[23];
                        bit_cnt <= 5'd23;
                    end else begin
                        refresh_cnt <= refresh_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    state   <= SHIFT_LO;
                    div_cnt <= DIV_LOAD;
                end
                SHIFT_LO: begin
                    if (div_cnt == '0) begin
                        state   <= SHIFT_HI;
                        sr_clk  <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == '0) begin
                        sr_clk  <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == '0) begin
                            state    <= LATCH;
                            sr_latch <= 1'b1;
                        end else begin
                            state   <= SHIFT_LO;
                            bit_cnt <= bit_cnt - 1'b1;
                            sr_data <= shift_reg[22];
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                LATCH: begin
                    if (div_cnt == '0) begin
                        state       <= IDLE;
                        sr_latch    <= 1'b0;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        sr_data     <= 1'b0;
                        refresh_cnt <= REF_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_led_shift.sv
// Bench for panel_led_shift: two instances (CLK_DIV=4 and CLK_DIV=1) watched by a bus monitor.
module tb_panel_led_shift;

    localparam int REFRESH = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [0:11] dout_a, dout_b;
    logic [0:4]  dsel_a, dsel_b;
    logic        run_a, run_b;
    logic [1:0]  sd, sc, sl, bz, fd;

    int checks = 0;
    int failures = 0;

    panel_led_shift #(.CLK_DIV(4), .REFRESH(REFRESH)) dut4 (
        .clk(clk), .reset(reset), .dout(dout_a), .dsel_led(dsel_a), .run_led(run_a),
        .sr_data(sd[0]), .sr_clk(sc[0]), .sr_latch(sl[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    panel_led_shift #(.CLK_DIV(1), .REFRESH(REFRESH)) dut1 (
        .clk(clk), .reset(reset), .dout(dout_b), .dsel_led(dsel_b), .run_led(run_b),
        .sr_data(sd[1]), .sr_clk(sc[1]), .sr_latch(sl[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    // Observed bus activity, per instance
    int          cyc = 0;
    logic [23:0] acc [2];
    int          nbits [2];
    int          busy_run [2];
    int          lat_run [2];
    int          nload [2];
    int          nlat [2];
    int          nlatw [2];
    int          nbusy [2];
    int          ndone [2];
    int          fd_wide [2];
    int          setup_err [2];
    int          idle_err [2];
    int          notoggle [2];
    logic [23:0] fr_word [2][256];
    int          fr_bits [2][256];
    int          fr_latw [2][256];
    int          fr_busy [2][256];
    int          load_cyc [2][256];
    int          done_cyc [2][256];

    // Reference: place each field by its bit-numbering rule using plain arithmetic.
    function automatic logic [23:0] model(input logic [0:11] d, input logic [0:4] s, input logic r);
        int dn = 0;
        int sn = 0;
        for (int k = 0; k < 12; k++) dn = dn * 2 + int'(d[k]);
        for (int k = 0; k < 5; k++)  sn = sn * 2 + int'(s[k]);
        return 24'(int'(r) * 131072 + sn * 4096 + dn);
    endfunction

    function automatic logic [7:0] ix(input int n);
        return n[7:0];
    endfunction

    function automatic int get_cnt(input int which, input int i);
        case (which)
            0:       return nload[i];
            1:       return nlat[i];
            2:       return nlatw[i];
            3:       return ndone[i];
            4:       return nbits[i];
            default: return nbusy[i];
        endcase
    endfunction

    initial begin
        logic [1:0] p_sd, p_sc, p_sl, p_bz, p_fd;
        p_sd = '0; p_sc = '0; p_sl = '0; p_bz = '0; p_fd = '0;
        for (int i = 0; i < 2; i++) begin
            acc[i] = '0; nbits[i] = 0; busy_run[i] = 0; lat_run[i] = 0;
            nload[i] = 0; nlat[i] = 0; nlatw[i] = 0; nbusy[i] = 0; ndone[i] = 0;
            fd_wide[i] = 0; setup_err[i] = 0; idle_err[i] = 0; notoggle[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (reset !== 1'b1) begin
                    acc[i] = '0;
                    nbits[i] = 0;
                end else if (sc[i] && !p_sc[i]) begin
                    acc[i] = {acc[i][22:0], sd[i]};
                    nbits[i]++;
                end
                if (sl[i] && !p_sl[i]) begin
                    fr_word[i][ix(nlat[i])] = acc[i];
                    fr_bits[i][ix(nlat[i])] = nbits[i];
                    nlat[i]++;
                    lat_run[i] = 0;
                end
                if (sl[i]) lat_run[i]++;
                if (!sl[i] && p_sl[i]) begin
                    fr_latw[i][ix(nlatw[i])] = lat_run[i];
                    nlatw[i]++;
                    acc[i] = '0;
                    nbits[i] = 0;
                end
                if (bz[i] && !p_bz[i]) begin
                    load_cyc[i][ix(nload[i])] = cyc;
                    nload[i]++;
                    busy_run[i] = 0;
                end
                if (bz[i]) busy_run[i]++;
                if (bz[i] && p_bz[i] && busy_run[i] >= 3 && !sl[i] && sc[i] == p_sc[i]) notoggle[i]++;
                if (!bz[i] && p_bz[i]) begin
                    fr_busy[i][ix(nbusy[i])] = busy_run[i];
                    nbusy[i]++;
                end
                if (fd[i] && !p_fd[i]) begin
                    done_cyc[i][ix(ndone[i])] = cyc;
                    ndone[i]++;
                end
                if (fd[i] && p_fd[i]) fd_wide[i]++;
                if (bz[i] && p_bz[i] && sd[i] != p_sd[i] && !(p_sc[i] && !sc[i])) setup_err[i]++;
                if (!bz[i] && sd[i]) idle_err[i]++;
            end
            p_sd = sd; p_sc = sc; p_sl = sl; p_bz = bz; p_fd = fd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input int which, input int i, input int target, input string tag);
        int n = 0;
        while (get_cnt(which, i) < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (get_cnt(which, i) >= target) else begin
            failures++;
            $error("FAIL %s timeout observed=%0d expected=%0d", tag, get_cnt(which, i), target);
        end
    endtask

    initial begin
        int lat0, done0, k, exp_gap;
        reset  = 1'b0;
        dout_a = 12'o1111;
        dsel_a = 5'b00001;
        run_a  = 1'b1;
        dout_b = 12'($urandom);
        dsel_b = 5'($urandom);
        run_b  = 1'($urandom);

        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_sr_data%0d", i),    32'(sd[i]), 32'd0);
            chk($sformatf("rst_sr_clk%0d", i),     32'(sc[i]), 32'd0);
            chk($sformatf("rst_sr_latch%0d", i),   32'(sl[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i),       32'(bz[i]), 32'd0);
            chk($sformatf("rst_frame_done%0d", i), 32'(fd[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_after_release4", 32'(bz[0]), 32'd1);
        chk("busy_after_release1", 32'(bz[1]), 32'd1);

        // First frame on both instances
        wait_cnt(3, 0, 1, "first_done4");
        chk("frame_word4",  32'(fr_word[0][0]), 32'h021249);
        chk("frame_bits4",  32'(fr_bits[0][0]), 32'd24);
        chk("latch_width4", 32'(fr_latw[0][0]), 32'd4);
        chk("latch_count4", 32'(nlat[0]),       32'd1);
        chk("busy_len4",    32'(fr_busy[0][0]), 32'd197);
        chk("done_single4", 32'(fd_wide[0]),    32'd0);
        wait_cnt(3, 1, 1, "first_done1");
        chk("frame_word1",  32'(fr_word[1][0]), 32'(model(dout_b, dsel_b, run_b)));
        chk("frame_bits1",  32'(fr_bits[1][0]), 32'd24);
        chk("latch_width1", 32'(fr_latw[1][0]), 32'd1);
        chk("busy_len1",    32'(fr_busy[1][0]), 32'd50);
        chk("toggle1",      32'(notoggle[1]),   32'd0);

        // Periodic refresh spacing
        wait_cnt(0, 0, 2, "second_load4");
        chk("refresh_gap4", 32'(load_cyc[0][1] - done_cyc[0][0]), 32'(REFRESH));

        // Input change in the middle of shifting
        wait_cnt(4, 0, 8, "mid_shift4");
        dout_a = 12'o7777;
        wait_cnt(3, 0, 2, "midchg_done4");
        chk("midchg_word4", 32'(fr_word[0][1]), 32'h021249);
        wait_cnt(0, 0, 3, "midchg_next_load4");
`ifdef LED_CHANGE_EN
        exp_gap = 1;
`else
        exp_gap = REFRESH;
`endif
        chk("midchg_gap4", 32'(load_cyc[0][2] - done_cyc[0][1]), 32'(exp_gap));
        wait_cnt(3, 0, 3, "midchg_next_done4");
        chk("midchg_next_word4", 32'(fr_word[0][2]), 32'h021FFF);

        // Reset after ten shifted bits
        wait_cnt(0, 0, 4, "abort_load4");
        wait_cnt(4, 0, 10, "abort_bits4");
        lat0  = nlat[0];
        done0 = ndone[0];
        reset = 1'b0;
        #1;
        chk("abort_sr_data4",  32'(sd[0]), 32'd0);
        chk("abort_sr_clk4",   32'(sc[0]), 32'd0);
        chk("abort_sr_latch4", 32'(sl[0]), 32'd0);
        chk("abort_busy4",     32'(bz[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cnt(3, 0, done0 + 1, "restart_done4");
        chk("abort_no_latch4", 32'(nlat[0] - lat0),            32'd1);
        chk("restart_word4",   32'(fr_word[0][ix(lat0)]),      32'(model(dout_a, dsel_a, run_a)));
        chk("restart_bits4",   32'(fr_bits[0][ix(lat0)]),      32'd24);
        chk("restart_busy4",   32'(fr_busy[0][ix(nbusy[0]-1)]), 32'd197);

        // Randomised frames
        for (int n = 0; n < 5; n++) begin
            wait_cnt(3, 0, ndone[0] + 1, "rand_idle4");
            dout_a = 12'($urandom);
            dsel_a = 5'($urandom);
            run_a  = 1'($urandom);
            k = nlat[0];
            wait_cnt(2, 0, k + 1, "rand_frame4");
            chk($sformatf("rand_word4_%0d", n), 32'(fr_word[0][ix(k)]), 32'(model(dout_a, dsel_a, run_a)));
            chk($sformatf("rand_bits4_%0d", n), 32'(fr_bits[0][ix(k)]), 32'd24);
        end
        for (int n = 0; n < 5; n++) begin
            wait_cnt(3, 1, ndone[1] + 1, "rand_idle1");
            dout_b = 12'($urandom);
            dsel_b = 5'($urandom);
            run_b  = 1'($urandom);
            k = nlat[1];
            wait_cnt(2, 1, k + 1, "rand_frame1");
            chk($sformatf("rand_word1_%0d", n), 32'(fr_word[1][ix(k)]), 32'(model(dout_b, dsel_b, run_b)));
        end

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("setup_hold%0d", i),  32'(setup_err[i]), 32'd0);
            chk($sformatf("idle_data%0d", i),   32'(idle_err[i]),  32'd0);
            chk($sformatf("done_pulse%0d", i),  32'(fd_wide[i]),   32'd0);
        end
        chk("toggle1_final", 32'(notoggle[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
